control_unit_legv8: RTL and testbench

CONTROL_UNIT_LEGV8 -- requirements
Module: control_unit_legv8

---
 rtl/control_unit_legv8_pkg.sv | 187 ++++++++++++++++++
 rtl/control_unit_legv8_if.sv | 11 +
 rtl/legv8_const_gen.sv | 36 +++
 rtl/control_unit_legv8.sv | 133 +++++++++++++
 tb/tb_control_unit_legv8.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/control_unit_legv8_pkg.sv
// Shared encodings for the two-cycle LEGv8 control unit: opcodes, FS codes, control word layout.
// Defining LEGV8_BCOND_EN enables B.cond decode; without it that opcode decodes as illegal.
package control_unit_legv8_pkg;

  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_EXECUTE = 2'b01
  } state_e;

  localparam logic [4:0] FS_AND  = 5'b00000;
  localparam logic [4:0] FS_ORR  = 5'b00100;
  localparam logic [4:0] FS_ADD  = 5'b01000;
  localparam logic [4:0] FS_SUB  = 5'b01001;
  localparam logic [4:0] FS_EOR  = 5'b01100;
  localparam logic [4:0] FS_PASSB = 5'b10000;
  localparam logic [4:0] FS_LSL  = 5'b10100;
  localparam logic [4:0] FS_LSR  = 5'b11000;
  localparam logic [4:0] FS_MOVK = 5'b11100;

  localparam logic [1:0] DS_ALU = 2'b00;
  localparam logic [1:0] DS_MEM = 2'b01;
  localparam logic [1:0] DS_PC4 = 2'b10;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_REL  = 2'b01;
  localparam logic [1:0] PC_REG  = 2'b10;
  localparam logic [1:0] PC_HOLD = 2'b11;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_ANDS = 11'b11101010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_BR   = 11'b11010110000;

  localparam logic [9:0] OP_ADDI  = 10'b1001000100;
  localparam logic [9:0] OP_ADDIS = 10'b1011000100;
  localparam logic [9:0] OP_SUBI  = 10'b1101000100;
  localparam logic [9:0] OP_SUBIS = 10'b1111000100;
  localparam logic [9:0] OP_ANDI  = 10'b1001001000;
  localparam logic [9:0] OP_ORRI  = 10'b1011001000;
  localparam logic [9:0] OP_EORI  = 10'b1101001000;
  localparam logic [9:0] OP_ANDIS = 10'b1111001000;

  localparam logic [8:0] OP_MOVZ = 9'b110100101;
  localparam logic [8:0] OP_MOVK = 9'b111100101;

  localparam logic [7:0] OP_CBZ   = 8'b10110100;
  localparam logic [7:0] OP_CBNZ  = 8'b10110101;
  localparam logic [7:0] OP_BCOND = 8'b01010100;

  localparam logic [5:0] OP_B  = 6'b000101;
  localparam logic [5:0] OP_BL = 6'b100101;

  // Field order fixes the bit positions: state[33:32] down to da[4:0].
  typedef struct packed {
    logic [1:0] state;
    logic       illegal;
    logic       memread;
    logic       irload;
    logic       movkeep;
    logic       statusload;
    logic [1:0] pcsel;
    logic [1:0] datasel;
    logic       memwrite;
    logic       regwrite;
    logic       bsel;
    logic [4:0] fs;
    logic [4:0] sb;
    logic [4:0] sa;
    logic [4:0] da;
  } ctrl_word_t;

  typedef enum logic [4:0] {
    C_ADD, C_SUB, C_ADDS, C_SUBS, C_AND, C_ORR, C_EOR, C_ANDS,
    C_ADDI, C_SUBI, C_ADDIS, C_SUBIS, C_ANDI, C_ORRI, C_EORI, C_ANDIS,
    C_LSL, C_LSR, C_LDUR, C_STUR, C_MOVZ, C_MOVK,
    C_CBZ, C_CBNZ, C_BCOND, C_B, C_BL, C_BR, C_ILLEGAL
  } instr_class_e;

  // Opcode widths differ per format, so try the widest field first.
  function automatic instr_class_e decode_class(input logic [31:0] instr);
    instr_class_e cls;
    cls = C_ILLEGAL;
    case (instr[31:21])
      OP_ADD:  cls = C_ADD;
      OP_SUB:  cls = C_SUB;
      OP_ADDS: cls = C_ADDS;
      OP_SUBS: cls = C_SUBS;
      OP_AND:  cls = C_AND;
      OP_ORR:  cls = C_ORR;
      OP_EOR:  cls = C_EOR;
      OP_ANDS: cls = C_ANDS;
      OP_LSL:  cls = C_LSL;
      OP_LSR:  cls = C_LSR;
      OP_LDUR: cls = C_LDUR;
      OP_STUR: cls = C_STUR;
      OP_BR:   cls = C_BR;
      default: cls = C_ILLEGAL;
    endcase
    if (cls == C_ILLEGAL) begin
      case (instr[31:22])
        OP_ADDI:  cls = C_ADDI;
        OP_ADDIS: cls = C_ADDIS;
        OP_SUBI:  cls = C_SUBI;
        OP_SUBIS: cls = C_SUBIS;
        OP_ANDI:  cls = C_ANDI;
        OP_ORRI:  cls = C_ORRI;
        OP_EORI:  cls = C_EORI;
        OP_ANDIS: cls = C_ANDIS;
        default:  cls = C_ILLEGAL;
      endcase
    end
    if (cls == C_ILLEGAL) begin
      case (instr[31:23])
        OP_MOVZ: cls = C_MOVZ;
        OP_MOVK: cls = C_MOVK;
        default: cls = C_ILLEGAL;
      endcase
    end
    if (cls == C_ILLEGAL) begin
      case (instr[31:24])
        OP_CBZ:   cls = C_CBZ;
        OP_CBNZ:  cls = C_CBNZ;
`ifdef LEGV8_BCOND_EN
        OP_BCOND: cls = C_BCOND;
`endif
        default:  cls = C_ILLEGAL;
      endcase
    end
    if (cls == C_ILLEGAL) begin
      case (instr[31:26])
        OP_B:    cls = C_B;
        OP_BL:   cls = C_BL;
        default: cls = C_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

  function automatic logic [4:0] alu_fs(input instr_class_e cls);
    logic [4:0] fs;
    case (cls)
      C_ADD, C_ADDS, C_ADDI, C_ADDIS: fs = FS_ADD;
      C_SUB, C_SUBS, C_SUBI, C_SUBIS: fs = FS_SUB;
      C_ORR, C_ORRI:                  fs = FS_ORR;
      C_EOR, C_EORI:                  fs = FS_EOR;
      C_LSL:                          fs = FS_LSL;
      C_LSR:                          fs = FS_LSR;
      default:                        fs = FS_AND;
    endcase
    return fs;
  endfunction

  function automatic logic sets_flags(input instr_class_e cls);
    return (cls == C_ADDS) || (cls == C_SUBS) || (cls == C_ANDS) ||
           (cls == C_ADDIS) || (cls == C_SUBIS) || (cls == C_ANDIS);
  endfunction

  // flags: [0]=Z [1]=N [2]=C [3]=V; odd codes invert the even one, 111x is always.
  function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] flags);
    logic z, n, c, v, base;
    z = flags[0];
    n = flags[1];
    c = flags[2];
    v = flags[3];
    case (cond[3:1])
      3'b000:  base = z;
      3'b001:  base = c;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = c & ~z;
      3'b101:  base = (n == v);
      3'b110:  base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (cond[3:1] == 3'b111) ? 1'b1 : (base ^ cond[0]);
  endfunction

endpackage

// File: rtl/control_unit_legv8_if.sv
// Instruction/status inputs and control word/constant outputs of the LEGv8 control unit.
// master drives the instruction side; slave is the control unit itself.
interface control_unit_legv8_if;
  logic [31:0] instruction;
  logic [4:0]  status;
  logic [33:0] ControlWord;
  logic [63:0] constant;

  modport master (output instruction, output status, input ControlWord, input constant);
  modport slave  (input instruction, input status, output ControlWord, output constant);
endinterface

// File: rtl/legv8_const_gen.sv
// Immediate extraction for every LEGv8 format; zero for formats without an immediate.
// B.cond immediates exist only when LEGV8_BCOND_EN is defined (via the shared decoder).
module legv8_const_gen
  import control_unit_legv8_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [63:0] constant
);

  instr_class_e cls;
  logic [63:0]  mov_imm;

  assign cls     = decode_class(instruction);
  assign mov_imm = {48'd0, instruction[20:5]} << {instruction[22:21], 4'b0000};

  always_comb begin
    constant = '0;
    case (cls)
      C_ADDI, C_SUBI, C_ADDIS, C_SUBIS, C_ANDI, C_ORRI, C_EORI, C_ANDIS:
        constant = {52'd0, instruction[21:10]};
      C_LSL, C_LSR:
        constant = {58'd0, instruction[15:10]};
      C_LDUR, C_STUR:
        constant = {{55{instruction[20]}}, instruction[20:12]};
      C_MOVZ, C_MOVK:
        constant = mov_imm;
      C_CBZ, C_CBNZ, C_BCOND:
        constant = {{43{instruction[23]}}, instruction[23:5], 2'b00};
      C_B, C_BL:
        constant = {{36{instruction[25]}}, instruction[25:0], 2'b00};
      default:
        constant = '0;
    endcase
  end

endmodule

// File: rtl/control_unit_legv8.sv
// Two-state (FETCH/EXECUTE) LEGv8 control unit producing a 34-bit control word and a 64-bit constant.
// B.cond decode is enabled by defining LEGV8_BCOND_EN.
module control_unit_legv8
  import control_unit_legv8_pkg::*;
(
  input logic                 clock,
  input logic                 reset,
  control_unit_legv8_if.slave cu
);

  state_e       state, state_next;
  instr_class_e cls;
  ctrl_word_t   cw;
  logic [63:0]  imm;
  logic [4:0]   rd, rn, rm;

  assign rd  = cu.instruction[4:0];
  assign rn  = cu.instruction[9:5];
  assign rm  = cu.instruction[20:16];
  assign cls = decode_class(cu.instruction);

  legv8_const_gen u_const_gen (
    .instruction (cu.instruction),
    .constant    (imm)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Everything below is combinational, so a reset in EXECUTE leaves nothing pending.
  always_comb begin
    state_next = S_FETCH;
    cw         = '0;
    case (state)
      S_FETCH: begin
        state_next = S_EXECUTE;
        cw.state   = S_FETCH;
        cw.irload  = 1'b1;
        cw.memread = 1'b1;
        cw.pcsel   = PC_HOLD;
      end
      S_EXECUTE: begin
        state_next = S_FETCH;
        cw.state   = S_EXECUTE;
        cw.pcsel   = PC_NEXT;
        cw.datasel = DS_ALU;
        case (cls)
          C_ADD, C_SUB, C_ADDS, C_SUBS, C_AND, C_ORR, C_EOR, C_ANDS: begin
            cw.da         = rd;
            cw.sa         = rn;
            cw.sb         = rm;
            cw.fs         = alu_fs(cls);
            cw.regwrite   = 1'b1;
            cw.statusload = sets_flags(cls);
          end
          C_ADDI, C_SUBI, C_ADDIS, C_SUBIS, C_ANDI, C_ORRI, C_EORI, C_ANDIS,
          C_LSL, C_LSR: begin
            cw.da         = rd;
            cw.sa         = rn;
            cw.fs         = alu_fs(cls);
            cw.bsel       = 1'b1;
            cw.regwrite   = 1'b1;
            cw.statusload = sets_flags(cls);
          end
          C_LDUR: begin
            cw.da       = rd;
            cw.sa       = rn;
            cw.fs       = FS_ADD;
            cw.bsel     = 1'b1;
            cw.memread  = 1'b1;
            cw.datasel  = DS_MEM;
            cw.regwrite = 1'b1;
          end
          C_STUR: begin
            cw.sa       = rn;
            cw.sb       = rd;
            cw.fs       = FS_ADD;
            cw.bsel     = 1'b1;
            cw.memwrite = 1'b1;
          end
          C_MOVZ: begin
            cw.da       = rd;
            cw.fs       = FS_PASSB;
            cw.bsel     = 1'b1;
            cw.regwrite = 1'b1;
          end
          C_MOVK: begin
            cw.da       = rd;
            cw.sa       = rd;
            cw.fs       = FS_MOVK;
            cw.movkeep  = 1'b1;
            cw.bsel     = 1'b1;
            cw.regwrite = 1'b1;
          end
          C_CBZ, C_CBNZ: begin
            cw.sa    = rd;
            cw.sb    = 5'd31;
            cw.fs    = FS_ORR;
            cw.pcsel = (cu.status[4] ^ (cls == C_CBNZ)) ? PC_REL : PC_NEXT;
          end
`ifdef LEGV8_BCOND_EN
          C_BCOND: begin
            cw.pcsel = cond_met(cu.instruction[3:0], cu.status[3:0]) ? PC_REL : PC_NEXT;
          end
`endif
          C_B: begin
            cw.pcsel = PC_REL;
          end
          C_BL: begin
            cw.pcsel    = PC_REL;
            cw.da       = 5'd30;
            cw.datasel  = DS_PC4;
            cw.regwrite = 1'b1;
          end
          C_BR: begin
            cw.sa    = rn;
            cw.pcsel = PC_REG;
          end
          default: begin
            cw.illegal = 1'b1;
          end
        endcase
      end
      default: state_next = S_FETCH;
    endcase
  end

  assign cu.ControlWord = cw;
  assign cu.constant    = (state == S_EXECUTE) ? imm : 64'd0;

endmodule

// File: tb/tb_control_unit_legv8.sv
// Table-driven bench for control_unit_legv8 with a scoreboard queue of expected EXECUTE words.
module tb_control_unit_legv8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  control_unit_legv8_if cu_if ();
  control_unit_legv8 dut (.clock(clock), .reset(reset), .cu(cu_if));

  localparam logic [33:0] FETCH_WORD = 34'h0_6600_0000;
  localparam int F_AND = 0, F_ORR = 4, F_ADD = 8, F_SUB = 9, F_EOR = 12;
  localparam int F_PASSB = 16, F_LSL = 20, F_LSR = 24, F_MOVK = 28;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [4:0]  status;
    logic [33:0] cw;
    logic [63:0] k;
  } vec_t;

  typedef struct {
    string       name;
    logic [33:0] cw;
    logic [63:0] k;
  } exp_t;

  vec_t vecs[$];
  exp_t scoreboard[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  // Packs an EXECUTE-state control word from its fields.
  function automatic logic [33:0] xw(input int da, input int sa, input int sb, input int fs,
                                     input int bsel, input int rw, input int mw, input int ds,
                                     input int pc, input int sl, input int mk, input int mr,
                                     input int ill);
    return {2'b01, 1'(ill), 1'(mr), 1'b0, 1'(mk), 1'(sl), 2'(pc), 2'(ds), 1'(mw), 1'(rw),
            1'(bsel), 5'(fs), 5'(sb), 5'(sa), 5'(da)};
  endfunction

  function automatic void addv(input string name, input logic [31:0] instr,
                               input logic [4:0] status, input logic [33:0] cw,
                               input logic [63:0] k);
    vec_t v;
    v.name = name; v.instr = instr; v.status = status; v.cw = cw; v.k = k;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [33:0] exp_cw, input logic [63:0] exp_k);
    checks++;
    if (cu_if.ControlWord !== exp_cw || cu_if.constant !== exp_k) begin
      failures++;
      $display("FAIL %s: ControlWord=%h constant=%h, required ControlWord=%h constant=%h",
               name, cu_if.ControlWord, cu_if.constant, exp_cw, exp_k);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    cu_if.instruction = 32'd0;
    cu_if.status = 5'd0;

    addv("add",   32'h8B1F0040, 5'd0, xw(0,2,31,F_ADD,0,1,0,0,0,0,0,0,0), 64'd0);
    addv("subs",  {11'b11101011000,5'd5,6'd0,5'd4,5'd3}, 5'd0, xw(3,4,5,F_SUB,0,1,0,0,0,1,0,0,0), 64'd0);
    addv("sub",   {11'b11001011000,5'd7,6'd0,5'd8,5'd9}, 5'd0, xw(9,8,7,F_SUB,0,1,0,0,0,0,0,0,0), 64'd0);
    addv("adds",  {11'b10101011000,5'd1,6'd0,5'd2,5'd3}, 5'd0, xw(3,2,1,F_ADD,0,1,0,0,0,1,0,0,0), 64'd0);
    addv("and",   {11'b10001010000,5'd4,6'd0,5'd5,5'd6}, 5'd0, xw(6,5,4,F_AND,0,1,0,0,0,0,0,0,0), 64'd0);
    addv("orr",   {11'b10101010000,5'd7,6'd0,5'd8,5'd9}, 5'd0, xw(9,8,7,F_ORR,0,1,0,0,0,0,0,0,0), 64'd0);
    addv("eor",   {11'b11001010000,5'd10,6'd0,5'd11,5'd12}, 5'd0, xw(12,11,10,F_EOR,0,1,0,0,0,0,0,0,0), 64'd0);
    addv("ands",  {11'b11101010000,5'd13,6'd0,5'd14,5'd15}, 5'd0, xw(15,14,13,F_AND,0,1,0,0,0,1,0,0,0), 64'd0);
    addv("addi",  {10'b1001000100,12'hFFF,5'd2,5'd1}, 5'd0, xw(1,2,0,F_ADD,1,1,0,0,0,0,0,0,0), 64'hFFF);
    addv("subis", {10'b1111000100,12'h123,5'd4,5'd5}, 5'd0, xw(5,4,0,F_SUB,1,1,0,0,0,1,0,0,0), 64'h123);
    addv("orri",  {10'b1011001000,12'h800,5'd6,5'd7}, 5'd0, xw(7,6,0,F_ORR,1,1,0,0,0,0,0,0,0), 64'h800);
    addv("andis", {10'b1111001000,12'h0F0,5'd1,5'd1}, 5'd0, xw(1,1,0,F_AND,1,1,0,0,0,1,0,0,0), 64'hF0);
    addv("lsl",   {11'b11010011011,5'd0,6'd63,5'd7,5'd8}, 5'd0, xw(8,7,0,F_LSL,1,1,0,0,0,0,0,0,0), 64'd63);
    addv("lsr",   {11'b11010011010,5'd0,6'd5,5'd1,5'd2}, 5'd0, xw(2,1,0,F_LSR,1,1,0,0,0,0,0,0,0), 64'd5);
    addv("ldur",  {11'b11111000010,9'h1FF,2'b00,5'd3,5'd4}, 5'd0, xw(4,3,0,F_ADD,1,1,0,1,0,0,0,1,0), 64'hFFFF_FFFF_FFFF_FFFF);
    addv("stur",  {11'b11111000000,9'd8,2'b00,5'd6,5'd9}, 5'd0, xw(0,6,9,F_ADD,1,0,1,0,0,0,0,0,0), 64'd8);
    addv("movk",  {9'b111100101,2'd2,16'hABCD,5'd10}, 5'd0, xw(10,10,0,F_MOVK,1,1,0,0,0,0,1,0,0), 64'h0000_ABCD_0000_0000);
    addv("movz3", {9'b110100101,2'd3,16'h1234,5'd11}, 5'd0, xw(11,0,0,F_PASSB,1,1,0,0,0,0,0,0,0), 64'h1234_0000_0000_0000);
    addv("movz0", {9'b110100101,2'd0,16'hFFFF,5'd0}, 5'd0, xw(0,0,0,F_PASSB,1,1,0,0,0,0,0,0,0), 64'hFFFF);
    addv("cbz_t", {8'b10110100,19'd1,5'd2}, 5'b10000, xw(0,2,31,F_ORR,0,0,0,0,1,0,0,0,0), 64'd4);
    addv("cbz_n", {8'b10110100,19'd1,5'd2}, 5'b01111, xw(0,2,31,F_ORR,0,0,0,0,0,0,0,0,0), 64'd4);
    addv("cbnz_t", {8'b10110101,19'h7FFFE,5'd3}, 5'b00000, xw(0,3,31,F_ORR,0,0,0,0,1,0,0,0,0), 64'hFFFF_FFFF_FFFF_FFF8);
    addv("cbnz_n", {8'b10110101,19'h7FFFE,5'd3}, 5'b10000, xw(0,3,31,F_ORR,0,0,0,0,0,0,0,0,0), 64'hFFFF_FFFF_FFFF_FFF8);
    addv("b",     {6'b000101,26'd3}, 5'd0, xw(0,0,0,0,0,0,0,0,1,0,0,0,0), 64'd12);
    addv("bl",    {6'b100101,26'h3FFFFFF}, 5'd0, xw(30,0,0,0,0,1,0,2,1,0,0,0,0), 64'hFFFF_FFFF_FFFF_FFFC);
    addv("br",    {11'b11010110000,5'd31,6'd0,5'd5,5'd0}, 5'd0, xw(0,5,0,0,0,0,0,0,2,0,0,0,0), 64'd0);
    addv("ill_ones", 32'hFFFF_FFFF, 5'd0, xw(0,0,0,0,0,0,0,0,0,0,0,0,1), 64'd0);
    addv("ill_zero", 32'h0000_0000, 5'd0, xw(0,0,0,0,0,0,0,0,0,0,0,0,1), 64'd0);
`ifdef LEGV8_BCOND_EN
    addv("beq_t", {8'b01010100,19'd2,1'b0,4'b0000}, 5'b00001, xw(0,0,0,0,0,0,0,0,1,0,0,0,0), 64'd8);
    addv("bgt_n", {8'b01010100,19'd2,1'b0,4'b1100}, 5'b00010, xw(0,0,0,0,0,0,0,0,0,0,0,0,0), 64'd8);
    addv("bhi_t", {8'b01010100,19'd2,1'b0,4'b1000}, 5'b00100, xw(0,0,0,0,0,0,0,0,1,0,0,0,0), 64'd8);
    addv("bal_t", {8'b01010100,19'd2,1'b0,4'b1110}, 5'b00000, xw(0,0,0,0,0,0,0,0,1,0,0,0,0), 64'd8);
`else
    addv("bcond_ill", {8'b01010100,19'd2,1'b0,4'b0000}, 5'b00001, xw(0,0,0,0,0,0,0,0,0,0,0,0,1), 64'd0);
`endif

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset_fetch", FETCH_WORD, 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      cu_if.instruction = vecs[i].instr;
      cu_if.status = vecs[i].status;
      e.name = vecs[i].name; e.cw = vecs[i].cw; e.k = vecs[i].k;
      scoreboard.push_back(e);
      #1 check({vecs[i].name, "_fetch"}, FETCH_WORD, 64'd0);
      tick();
      if (scoreboard.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty: no expected entry for %s", vecs[i].name);
      end else begin
        e = scoreboard.pop_front();
        check(e.name, e.cw, e.k);
      end
      tick();
    end

    // Status and instruction are live during EXECUTE.
    cu_if.instruction = {8'b10110100, 19'd1, 5'd2};
    cu_if.status = 5'b10000;
    tick();
    check("cbz_live_taken", xw(0,2,31,F_ORR,0,0,0,0,1,0,0,0,0), 64'd4);
    cu_if.status = 5'b00000;
    #1 check("cbz_live_not_taken", xw(0,2,31,F_ORR,0,0,0,0,0,0,0,0,0), 64'd4);
    cu_if.instruction = {11'b11010110000, 5'd0, 6'd0, 5'd5, 5'd0};
    #1 check("instr_live_br", xw(0,5,0,0,0,0,0,0,2,0,0,0,0), 64'd0);
    tick();
    check("after_live_fetch", FETCH_WORD, 64'd0);

    // Reset during EXECUTE aborts the store and holds FETCH while asserted.
    cu_if.instruction = {11'b11111000000, 9'd8, 2'b00, 5'd6, 5'd9};
    tick();
    check("stur_exec", xw(0,6,9,F_ADD,1,0,1,0,0,0,0,0,0), 64'd8);
    reset = 1'b1;
    tick();
    check("reset_mid_exec", FETCH_WORD, 64'd0);
    tick();
    check("reset_hold", FETCH_WORD, 64'd0);
    reset = 1'b0;
    tick();
    check("post_reset_exec", xw(0,6,9,F_ADD,1,0,1,0,0,0,0,0,0), 64'd8);
    tick();
    check("post_reset_fetch", FETCH_WORD, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
